// File: rtl/tx_pcs_encoder.sv
// ---------------------------------------------------------------------------
// tx_pcs_encoder
//
// Sits between tx_mac and the scrambler/gearbox in the 10G transmit path.
// Pairs consecutive 32-bit XGMII words into one 64-bit XGMII block and
// encodes it as a 64b/66b block (2-bit sync header + 64-bit payload).
// Only a completing (high) half is ever stalled, so upstream sees
// backpressure only when a block is ready to form and the output register
// is still occupied.
//
// Ports
//   tx_clk              : clock for the whole block
//   tx_rst              : synchronous, active-high reset
//   in_xgmii_data       : XGMII word, lane i = bits 8i+7:8i
//   in_xgmii_ctl        : per-lane control flags, bit i qualifies lane i
//   in_xgmii_valid      : word valid
//   out_xgmii_pcs_ready : ready back to tx_mac
//   out_pcs_header      : sync header, 2'b01 data / 2'b10 control
//   out_pcs_data        : encoded payload, block type in bits 7:0 if control
//   out_pcs_valid       : encoded block valid
//   in_pcs_ready        : downstream accept
//   out_err_count       : saturating count of error blocks emitted
//
// Half-word state machine
//   state   | meaning
//   ST_LOW  | next transferred word becomes lanes 0-3
//   ST_HIGH | lanes 0-3 buffered; next transferred word completes the block
// ---------------------------------------------------------------------------
module tx_pcs_encoder #(
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int XGMII_DATA_BYTES = 4,
    parameter int ERR_CNT_WIDTH    = 16
) (
    input  logic                        tx_clk,
    input  logic                        tx_rst,
    input  logic [XGMII_DATA_WIDTH-1:0] in_xgmii_data,
    input  logic [XGMII_DATA_BYTES-1:0] in_xgmii_ctl,
    input  logic                        in_xgmii_valid,
    output logic                        out_xgmii_pcs_ready,
    output logic [1:0]                  out_pcs_header,
    output logic [63:0]                 out_pcs_data,
    output logic                        out_pcs_valid,
    input  logic                        in_pcs_ready,
    output logic [ERR_CNT_WIDTH-1:0]    out_err_count
);

    localparam logic [1:0] SH_DATA    = 2'b01;
    localparam logic [1:0] SH_CTRL    = 2'b10;
    localparam logic [7:0] CH_IDLE    = 8'h07;
    localparam logic [7:0] CH_START   = 8'hFB;
    localparam logic [7:0] CH_TERM    = 8'hFD;
    localparam logic [7:0] CH_ERROR   = 8'hFE;
    localparam logic [7:0] BT_CTRL    = 8'h1E;
    localparam logic [7:0] BT_START   = 8'h78;
    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XGMII_DATA_WIDTH-1:0] r_low_data;
    logic [XGMII_DATA_BYTES-1:0] r_low_ctl;

    logic                     r_out_valid;
    logic [1:0]               r_out_header;
    logic [63:0]              r_out_data;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    logic        w_ready;
    logic        w_xfer;
    logic        w_complete;
    logic [63:0] w_blk_data;
    logic [7:0]  w_blk_ctl;
    logic        w_all_ctl;
    logic        w_term_hit;
    logic [2:0]  w_term_k;
    logic [1:0]  w_enc_header;
    logic [63:0] w_enc_data;
    logic        w_enc_err;

    function automatic logic [7:0] term_type(input logic [2:0] k);
        logic [7:0] t;
        case (k)
            3'd0:    t = 8'h87;
            3'd1:    t = 8'h99;
            3'd2:    t = 8'hAA;
            3'd3:    t = 8'hB4;
            3'd4:    t = 8'hCC;
            3'd5:    t = 8'hD2;
            3'd6:    t = 8'hE1;
            default: t = 8'hFF;
        endcase
        return t;
    endfunction

    // True when every lane above k carries idle.
    function automatic logic idle_above(input logic [63:0] d, input int k);
        logic ok;
        ok = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j > k && d[8*j +: 8] != CH_IDLE) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // A low half is always accepted; a completing half needs the output
    // register empty or draining this cycle.
    assign w_ready    = !((r_state == ST_HIGH) && r_out_valid && !in_pcs_ready);
    assign w_xfer     = in_xgmii_valid && w_ready;
    assign w_complete = w_xfer && (r_state == ST_HIGH);

    assign w_blk_data = {in_xgmii_data, r_low_data};
    assign w_blk_ctl  = {in_xgmii_ctl, r_low_ctl};

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            r_state <= ST_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOW:  if (w_xfer) w_state_nxt = ST_HIGH;
            ST_HIGH: if (w_xfer) w_state_nxt = ST_LOW;
            default: w_state_nxt = ST_LOW;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            r_low_data <= '0;
            r_low_ctl  <= '0;
        end else if (w_xfer && r_state == ST_LOW) begin
            r_low_data <= in_xgmii_data;
            r_low_ctl  <= in_xgmii_ctl;
        end
    end

    always_comb begin
        w_all_ctl = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (w_blk_data[8*i +: 8] != CH_IDLE && w_blk_data[8*i +: 8] != CH_ERROR) begin
                w_all_ctl = 1'b0;
            end
        end
    end

    // Terminate in lane k: ctl clear below k, set from k upward, /T/ in
    // lane k, idles after it. At most one k can satisfy the ctl pattern.
    always_comb begin
        w_term_hit = 1'b0;
        w_term_k   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (w_blk_ctl == (8'hFF << k) && w_blk_data[8*k +: 8] == CH_TERM &&
                idle_above(w_blk_data, k)) begin
                w_term_hit = 1'b1;
                w_term_k   = 3'(k);
            end
        end
    end

    always_comb begin
        w_enc_header = SH_CTRL;
        w_enc_data   = '0;
        w_enc_err    = 1'b0;
        if (w_blk_ctl == 8'h00) begin
            w_enc_header = SH_DATA;
            w_enc_data   = w_blk_data;
        end else if (w_blk_ctl == 8'hFF && w_all_ctl) begin
            w_enc_data[7:0] = BT_CTRL;
            for (int i = 0; i < 8; i++) begin
                w_enc_data[8+7*i +: 7] = (w_blk_data[8*i +: 8] == CH_ERROR) ? CODE_ERROR : CODE_IDLE;
            end
        end else if (w_blk_ctl == 8'h01 && w_blk_data[7:0] == CH_START) begin
            w_enc_data = {w_blk_data[63:8], BT_START};
        end else if (w_term_hit) begin
            w_enc_data[7:0] = term_type(w_term_k);
            for (int i = 0; i < 7; i++) begin
                if (i < int'(w_term_k)) begin
                    w_enc_data[8+8*i +: 8] = w_blk_data[8*i +: 8];
                end
            end
        end else begin
            w_enc_err       = 1'b1;
            w_enc_data[7:0] = BT_CTRL;
            for (int i = 0; i < 8; i++) begin
                w_enc_data[8+7*i +: 7] = CODE_ERROR;
            end
        end
    end

    // A completing half may land in the same cycle the previous block
    // drains, so the load branch takes priority over the clear.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            r_out_valid  <= 1'b0;
            r_out_header <= '0;
            r_out_data   <= '0;
            r_err_count  <= '0;
        end else if (w_complete) begin
            r_out_valid  <= 1'b1;
            r_out_header <= w_enc_header;
            r_out_data   <= w_enc_data;
            if (w_enc_err && r_err_count != '1) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end else if (r_out_valid && in_pcs_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_xgmii_pcs_ready = w_ready;
    assign out_pcs_valid       = r_out_valid;
    assign out_pcs_header      = r_out_header;
    assign out_pcs_data        = r_out_data;
    assign out_err_count       = r_err_count;

endmodule

// File: tb/tb_tx_pcs_encoder.sv
module tb_tx_pcs_encoder;

    logic        tx_clk = 1'b0;
    logic        tx_rst = 1'b1;
    logic [31:0] in_xgmii_data = '0;
    logic [3:0]  in_xgmii_ctl = '0;
    logic        in_xgmii_valid = 1'b0;
    logic        out_xgmii_pcs_ready;
    logic [1:0]  out_pcs_header;
    logic [63:0] out_pcs_data;
    logic        out_pcs_valid;
    logic        in_pcs_ready = 1'b1;
    logic [15:0] out_err_count;

    int n_checks = 0;
    int n_errors = 0;
    int dut_consumed = 0;

    tx_pcs_encoder #(
        .XGMII_DATA_WIDTH(32),
        .XGMII_DATA_BYTES(4),
        .ERR_CNT_WIDTH(16)
    ) dut (
        .tx_clk(tx_clk),
        .tx_rst(tx_rst),
        .in_xgmii_data(in_xgmii_data),
        .in_xgmii_ctl(in_xgmii_ctl),
        .in_xgmii_valid(in_xgmii_valid),
        .out_xgmii_pcs_ready(out_xgmii_pcs_ready),
        .out_pcs_header(out_pcs_header),
        .out_pcs_data(out_pcs_data),
        .out_pcs_valid(out_pcs_valid),
        .in_pcs_ready(in_pcs_ready),
        .out_err_count(out_err_count)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Encoder model: classify the block by inspecting lanes directly.
    function automatic void model_encode(input logic [63:0] d, input logic [7:0] c,
                                         output logic [1:0] h, output logic [63:0] p,
                                         output bit is_err);
        logic [7:0] ln [8];
        logic [7:0] ttab [8];
        bit allc;
        bit term;
        int k;
        ttab = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        for (int i = 0; i < 8; i++) ln[i] = d[8*i +: 8];
        is_err = 0;
        h = 2'b10;
        p = '0;
        allc = 1;
        for (int i = 0; i < 8; i++) if (!(ln[i] == 8'h07 || ln[i] == 8'hFE)) allc = 0;
        k = 8;
        for (int i = 7; i >= 0; i--) if (c[i]) k = i;
        term = (k < 8);
        if (term) begin
            for (int i = 0; i < 8; i++) if (i >= k && !c[i]) term = 0;
            if (ln[k % 8] != 8'hFD) term = 0;
            for (int i = 0; i < 8; i++) if (i > k && ln[i] != 8'h07) term = 0;
        end
        if (c == 8'h00) begin
            h = 2'b01;
            p = d;
        end else if (c == 8'hFF && allc) begin
            p = 64'h1E;
            for (int i = 0; i < 8; i++)
                if (ln[i] == 8'hFE) p = p | (64'h1E << (8 + 7*i));
        end else if (c == 8'h01 && ln[0] == 8'hFB) begin
            p = ((d >> 8) << 8) | 64'h78;
        end else if (term) begin
            p = 64'(ttab[k]);
            for (int i = 0; i < k; i++) p = p | (64'(ln[i]) << (8 + 8*i));
        end else begin
            is_err = 1;
            p = 64'h1E;
            for (int i = 0; i < 8; i++) p = p | (64'h1E << (8 + 7*i));
        end
    endfunction

    // Cycle model + compare process.
    bit          m_live = 0;
    bit          m_valid, m_half, m_ready, m_xfer, m_cons, m_eerr;
    logic [1:0]  m_hdr, m_ehdr;
    logic [63:0] m_data, m_edata;
    logic [31:0] m_low_d;
    logic [3:0]  m_low_c;
    logic [15:0] m_err;

    always @(negedge tx_clk) begin
        m_ready = !(m_half && m_valid && !in_pcs_ready);
        if (m_live) begin
            check("ready", 64'(out_xgmii_pcs_ready), 64'(m_ready));
            check("valid", 64'(out_pcs_valid), 64'(m_valid));
            if (m_valid) begin
                check("header", 64'(out_pcs_header), 64'(m_hdr));
                check("data", out_pcs_data, m_data);
            end
            check("err_count", 64'(out_err_count), 64'(m_err));
        end
        if (out_pcs_valid && in_pcs_ready && !tx_rst) dut_consumed++;
        if (tx_rst) begin
            m_live = 1; m_valid = 0; m_half = 0; m_err = '0;
            m_hdr = '0; m_data = '0;
        end else if (m_live) begin
            m_xfer = in_xgmii_valid && m_ready;
            m_cons = m_valid && in_pcs_ready;
            if (m_cons) m_valid = 0;
            if (m_xfer) begin
                if (!m_half) begin
                    m_low_d = in_xgmii_data;
                    m_low_c = in_xgmii_ctl;
                    m_half = 1;
                end else begin
                    model_encode({in_xgmii_data, m_low_d}, {in_xgmii_ctl, m_low_c},
                                 m_ehdr, m_edata, m_eerr);
                    m_hdr = m_ehdr;
                    m_data = m_edata;
                    m_valid = 1;
                    m_half = 0;
                    if (m_eerr && m_err != 16'hFFFF) m_err = m_err + 16'd1;
                end
            end
        end
    end

    task automatic sync();
        @(posedge tx_clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send_word(input logic [31:0] d, input logic [3:0] c);
        int n;
        n = 0;
        in_xgmii_data = d;
        in_xgmii_ctl = c;
        in_xgmii_valid = 1'b1;
        @(negedge tx_clk);
        while (!out_xgmii_pcs_ready && n < 200) begin
            @(negedge tx_clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 64'(out_xgmii_pcs_ready), 64'd1);
        sync();
        in_xgmii_valid = 1'b0;
    endtask

    task automatic expect_block(input string name, input logic [1:0] h, input logic [63:0] d);
        @(negedge tx_clk);
        check({name, "_valid"}, 64'(out_pcs_valid), 64'd1);
        check({name, "_hdr"}, 64'(out_pcs_header), 64'(h));
        check({name, "_data"}, out_pcs_data, d);
        sync();
    endtask

    logic [1:0]  ph;
    logic [63:0] pp;
    bit          pe;
    logic [7:0]  pat;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        // Pin the model against hand-computed blocks.
        model_encode(64'h0707070707070707, 8'hFF, ph, pp, pe);
        check("model_idle", pp, 64'h000000000000001E);
        model_encode(64'h11223344A1B2FEC3, 8'h04, ph, pp, pe);
        check("model_err", pp, 64'h3C78F1E3C78F1E1E);
        model_encode(64'h070707FD3E5F7A9B, 8'hF0, ph, pp, pe);
        check("model_term4", pp, 64'h0000003E5F7A9BCC);

        repeat (3) @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        @(negedge tx_clk);
        check("rst_valid", 64'(out_pcs_valid), 64'd0);
        check("rst_hdr", 64'(out_pcs_header), 64'd0);
        check("rst_data", out_pcs_data, 64'd0);
        check("rst_err", 64'(out_err_count), 64'd0);
        check("rst_ready", 64'(out_xgmii_pcs_ready), 64'd1);
        sync();

        // Idle block
        send_word(32'h07070707, 4'hF);
        send_word(32'h07070707, 4'hF);
        expect_block("idle", 2'b10, 64'h000000000000001E);
        check("idle_err", 64'(out_err_count), 64'd0);

        // Start + data
        send_word(32'h555555FB, 4'h1);
        send_word(32'hD5555555, 4'h0);
        expect_block("start", 2'b10, 64'hD555555555555578);
        send_word(32'h12345678, 4'h0);
        send_word(32'hDEADBEEF, 4'h0);
        expect_block("data", 2'b01, 64'hDEADBEEF12345678);

        // Terminate lanes 4, 0, 7
        send_word(32'h3E5F7A9B, 4'h0);
        send_word(32'h070707FD, 4'hF);
        expect_block("term4", 2'b10, 64'h0000003E5F7A9BCC);
        send_word(32'h070707FD, 4'hF);
        send_word(32'h07070707, 4'hF);
        expect_block("term0", 2'b10, 64'h0000000000000087);
        send_word(32'h44332211, 4'h0);
        send_word(32'hFD776655, 4'h8);
        expect_block("term7", 2'b10, 64'h77665544332211FF);

        // Error block, then start in lane 4 is also an error
        send_word(32'hA1B2FEC3, 4'b0100);
        send_word(32'h11223344, 4'h0);
        expect_block("err", 2'b10, 64'h3C78F1E3C78F1E1E);
        check("err_cnt1", 64'(out_err_count), 64'd1);
        send_word(32'h07070707, 4'hF);
        send_word(32'h555555FB, 4'h1);
        expect_block("start4", 2'b10, 64'h3C78F1E3C78F1E1E);
        check("err_cnt2", 64'(out_err_count), 64'd2);

        // Backpressure across 10 blocks
        in_pcs_ready = 1'b0;
        dut_consumed = 0;
        send_word(32'h11110000, 4'h0);
        send_word(32'h22220000, 4'h0);
        send_word(32'h11110001, 4'h0);
        in_xgmii_data = 32'h22220001;
        in_xgmii_ctl = 4'h0;
        in_xgmii_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge tx_clk);
            check("bp_ready", 64'(out_xgmii_pcs_ready), 64'd0);
            check("bp_valid", 64'(out_pcs_valid), 64'd1);
            check("bp_hold", out_pcs_data, 64'h2222000011110000);
            sync();
        end
        in_pcs_ready = 1'b1;
        send_word(32'h22220001, 4'h0);
        pat = 8'b1011_0110;
        fork
            begin
                for (int j = 2; j < 10; j++) begin
                    send_word(32'h11110000 + 32'(j), 4'h0);
                    if (j == 5) repeat (3) sync();
                    send_word(32'h22220000 + 32'(j), 4'h0);
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    in_pcs_ready = pat[c % 8];
                    sync();
                end
                in_pcs_ready = 1'b1;
            end
        join
        in_pcs_ready = 1'b1;
        repeat (4) sync();
        check("bp_consumed", 64'(dut_consumed), 64'd10);

        // Reset with a pending block and a buffered low half
        in_pcs_ready = 1'b0;
        send_word(32'h0BADF00D, 4'h0);
        send_word(32'h0BADCAFE, 4'h0);
        send_word(32'hFFFF0000, 4'h0);
        tx_rst = 1'b1;
        sync();
        tx_rst = 1'b0;
        in_pcs_ready = 1'b1;
        @(negedge tx_clk);
        check("mrst_valid", 64'(out_pcs_valid), 64'd0);
        check("mrst_err", 64'(out_err_count), 64'd0);
        check("mrst_ready", 64'(out_xgmii_pcs_ready), 64'd1);
        sync();
        send_word(32'hCAFEF00D, 4'h0);
        send_word(32'h01234567, 4'h0);
        expect_block("fresh", 2'b01, 64'h01234567CAFEF00D);

        repeat (3) sync();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx_pcs_encoder.md
Name: tx_pcs_encoder

Overview:
- Downstream neighbour of tx_mac in the 10G transmit path.
- Consumes the 32-bit XGMII stream (data/ctl/valid) that tx_mac produces and drives tx_mac's in_xgmii_pcs_ready.
- Pairs consecutive 32-bit words into 64-bit XGMII blocks and encodes each into a 64b/66b block (2-bit sync header + 64-bit payload) for the downstream scrambler/gearbox.
- Applies backpressure upstream when the downstream stage stalls.

Parameters:
- XGMII_DATA_WIDTH, 32, input XGMII data width; only 32 supported.
- XGMII_DATA_BYTES, 4, XGMII lanes per word.
- ERR_CNT_WIDTH, 16, width of the saturating error-block counter.

Ports:
- tx_clk  in  1  single clock for the whole block.
- tx_rst  in  1  synchronous, active-high reset.
- in_xgmii_data  in  32  XGMII data; lane i = bits 8i+7:8i.
- in_xgmii_ctl  in  4  per-lane control flags; bit i qualifies lane i.
- in_xgmii_valid  in  1  word valid.
- out_xgmii_pcs_ready  out  1  ready to tx_mac.
- out_pcs_header  out  2  sync header; 2'b01 = data, 2'b10 = control.
- out_pcs_data  out  64  encoded payload; block type in bits 7:0 for control blocks.
- out_pcs_valid  out  1  encoded block valid.
- in_pcs_ready  in  1  downstream accept.
- out_err_count  out  ERR_CNT_WIDTH  number of error blocks emitted, saturating.

Behaviour:
- Reset values: out_pcs_valid=0, out_pcs_header=0, out_pcs_data=0, out_err_count=0, half-word buffer empty.
  - out_xgmii_pcs_ready is 1 in the first cycle after reset deasserts.
  - A reset mid-block discards any buffered low half and any pending output.
- Word transfer occurs when in_xgmii_valid && out_xgmii_pcs_ready.
  - First transferred word is stored as lanes 0-3 (half_full=1).
  - Second transferred word forms lanes 4-7. The block is encoded and registered on that edge, so out_pcs_valid rises the cycle after the second transfer (latency 1).
- out_pcs_valid and out_pcs_data/out_pcs_header hold stable until in_pcs_ready=1. A block is consumed on out_pcs_valid && in_pcs_ready.
- out_xgmii_pcs_ready = !(half_full && out_pcs_valid && !in_pcs_ready).
  - A low half may always be accepted.
  - A completing half is accepted only if the output register is empty or draining in the same cycle.
  - Back-to-back blocks sustain full rate with in_pcs_ready held at 1.
- Encoding, with D = 8-lane data, C = 8-bit ctl (C[0] = lane 0). Classification is evaluated in this order:
  - All data: C=8'h00. Header 01, payload = D.
  - All control: C=8'hFF and every lane 0x07 (idle) or 0xFE (error). Header 10, type 0x1E. 7-bit code i occupies bits 8+7i+6:8+7i; idle→0x00, error→0x1E.
  - Start lane 0: C=8'h01, lane0=0xFB. Header 10, type 0x78, bits 63:8 = lanes 1..7.
  - Terminate lane k (k=0..7): C[k-1:0]=0, C[7:k] all 1, lane k=0xFD, lanes k+1..7 all 0x07.
    - Header 10.
    - Type for k=0..7 = 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF.
    - Data lanes 0..k-1 at bits 8+8i+7:8+8i.
    - All remaining payload bits are 0.
  - Anything else, including start in lane 4, misplaced 0xFD, or a non-idle after T: error block. Header 10, type 0x1E, all eight 7-bit codes 0x1E.
- Error counter: out_err_count increments by 1 on the cycle each error block (from the fallback rule only) is registered; it saturates at all-ones.
- Stall with a half buffered: the low half is retained indefinitely. in_xgmii_valid=0 between halves is legal; pairing resumes on the next transfer.

Test Plan:
1. Idle: two words 0x07070707, ctl 4'hF, in_pcs_ready=1 → one cycle later header 10, data 64'h000000000000001E; err_count 0.
2. Start+data:
   - 0x555555FB/ctl 4'h1 then 0xD5555555/ctl 0 → header 10, data 64'hD555555555555578.
   - Then 0x12345678, 0xDEADBEEF (ctl 0) → header 01, data 64'hDEADBEEF12345678 on the next cycle.
3. Terminate lane 4: 0x3E5F7A9B/ctl 0 then 0x070707FD/ctl 4'hF → header 10, data 64'h0000003E5F7A9BCC.
4. Backpressure:
   - Hold in_pcs_ready=0 with a block pending and a low half buffered → out_xgmii_pcs_ready=0, outputs stable.
   - Raise in_pcs_ready → that block transfers, the next completes, no word is lost or duplicated across 10 blocks.
5. Error: low word 0xA1B2FEC3 with ctl 4'b0100, high word data ctl 0 → header 10, type 0x1E, all codes 0x1E, err_count increments to 1.
6. Reset mid-block:
   - Assert tx_rst with a half buffered and out_pcs_valid=1 → next cycle out_pcs_valid=0, err_count=0.
   - Next two words after reset form a fresh block.
